// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the behavioural SRAM models.
//   COLL_WRITE_FIRST / COLL_READ_FIRST select what a read port returns
//   when it reads the word that port 0 is writing on the same edge.
//   byte_merge(old_word, new_word, mask) returns old_word with every byte
//   whose mask bit is set replaced by the matching byte of new_word.
//   The function works on a fixed maximum width. Callers size-cast their
//   operands up to it and cast the result back down to their own width.
package sram_pkg;

  localparam int COLL_WRITE_FIRST = 0;
  localparam int COLL_READ_FIRST  = 1;
  localparam int MERGE_MAX_WIDTH  = 1024;

  function automatic logic [MERGE_MAX_WIDTH-1:0] byte_merge(
    input logic [MERGE_MAX_WIDTH-1:0]   old_word,
    input logic [MERGE_MAX_WIDTH-1:0]   new_word,
    input logic [MERGE_MAX_WIDTH/8-1:0] mask
  );
    logic [MERGE_MAX_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < MERGE_MAX_WIDTH / 8; i++) begin
      if (mask[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: delay line for read data and its valid flag, with 1 or 2 stages.
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid, in_data   read launched at this edge and the word that was read
//   out_valid, out_data valid is a one-cycle strobe. data holds its value between strobes
// Reset clears every stage. A read that is still in flight is therefore dropped.
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_q1;
  logic [DATA_WIDTH-1:0] data_q1;

  // Data loads only on a valid read, so the output holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q1 <= 1'b0;
      data_q1  <= '0;
    end else begin
      valid_q1 <= in_valid;
      if (in_valid) data_q1 <= in_data;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  valid_q2;
    logic [DATA_WIDTH-1:0] data_q2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q2 <= 1'b0;
        data_q2  <= '0;
      end else begin
        valid_q2 <= valid_q1;
        if (valid_q1) data_q2 <= data_q1;
      end
    end

    assign out_valid = valid_q2;
    assign out_data  = data_q2;
  end else begin : g_lat1
    assign out_valid = valid_q1;
    assign out_data  = data_q1;
  end

endmodule

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: single-clock behavioural SRAM with one read/write port and one read-only port.
//   clk, rst_n                  clock and asynchronous active-low reset
//   csb0, web0, wmask0, addr0,  port 0: chip select (active low), write enable (active low),
//   din0, dout0, dout0_valid      byte mask, address, write data, read data and read strobe
//   csb1, addr1, dout1,         port 1: chip select (active low), address, read data and
//   dout1_valid                   read strobe
//   oob_err                     strobe: an access at the previous edge used an address >= DEPTH
//   collision                   strobe: a port 0 write and a port 1 read hit the same address
//   coll_cnt                    saturating count of collisions
// Request/response protocol: there is no backpressure.
//   - A port accepts a request at every rising edge where rst_n = 1 and its csb = 0.
//   - Each accepted read returns exactly one dout_valid pulse, READ_LATENCY cycles later,
//     in request order.
//   - A write returns no pulse.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 512,
  parameter int ADDR_WIDTH     = 9,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = COLL_WRITE_FIRST,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic                    dout0_valid,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic                    dout1_valid,
  output logic                    oob_err,
  output logic                    collision,
  output logic [CNT_WIDTH-1:0]    coll_cnt
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  oob0, oob1;
  logic                  wr_en, rd0_req, rd1_req, coll_now;
  logic [DATA_WIDTH-1:0] rd0_word, rd1_old, rd1_merged, rd1_word;

  // The compare uses one extra bit so that DEPTH == 2**ADDR_WIDTH does not wrap to 0.
  assign oob0 = ({1'b0, addr0} >= (ADDR_WIDTH+1)'(DEPTH));
  assign oob1 = ({1'b0, addr1} >= (ADDR_WIDTH+1)'(DEPTH));

  // Writes are gated by rst_n, so the array is never updated while reset is held.
  assign wr_en    = rst_n & ~csb0 & ~web0 & ~oob0;
  assign rd0_req  = ~csb0 & web0;
  assign rd1_req  = ~csb1;
  assign coll_now = wr_en & rd1_req & (addr0 == addr1);

  // An out-of-range read returns zero, never X from outside the array.
  assign rd0_word = oob0 ? '0 : mem[addr0];
  assign rd1_old  = oob1 ? '0 : mem[addr1];

  assign rd1_merged = DATA_WIDTH'(byte_merge(MERGE_MAX_WIDTH'(rd1_old),
                                             MERGE_MAX_WIDTH'(din0),
                                             (MERGE_MAX_WIDTH/8)'(wmask0)));
  assign rd1_word   = (coll_now && COLLISION_MODE == COLL_WRITE_FIRST) ? rd1_merged : rd1_old;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
      end
    end
  end

  // The strobes and the counter always have one cycle of latency, whatever READ_LATENCY is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_err   <= 1'b0;
      collision <= 1'b0;
      coll_cnt  <= '0;
    end else begin
      oob_err   <= (~csb0 & oob0) | (rd1_req & oob1);
      collision <= coll_now;
      if (coll_now && coll_cnt != '1) coll_cnt <= coll_cnt + CNT_WIDTH'(1);
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd0_req),
    .in_data  (rd0_word),
    .out_valid(dout0_valid),
    .out_data (dout0)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd1_req),
    .in_data  (rd1_word),
    .out_valid(dout1_valid),
    .out_data (dout1)
  );

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param: directed bench. Two instances share the same input stimulus.
//   u_a: DEPTH 500, latency 1, WRITE_FIRST, 2-bit counter
//   u_b: DEPTH 512, latency 2, READ_FIRST, 16-bit counter
// Expected read data is pushed to per-port queues. Expected {oob_err, collision}
// for every driven edge goes to per-instance queues. A negedge monitor pops and compares.
module tb_sram_1rw1r_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [8:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic        a_v0, a_v1, b_v0, b_v1;
  logic        a_oob, a_coll, b_oob, b_coll;
  logic [1:0]  a_cnt;
  logic [15:0] b_cnt;

  // Queue index: 0 = a port0, 1 = a port1, 2 = b port0, 3 = b port1.
  logic [31:0] exp_q[4][$];
  // Flag queue per instance holds {oob_err, collision}.
  logic [1:0]  flag_q[2][$];

  int n_vec  = 0;
  int n_fail = 0;

  string pname[4] = '{"a_dout0", "a_dout1", "b_dout0", "b_dout1"};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  sram_1rw1r_param #(
    .DATA_WIDTH(32), .DEPTH(500), .ADDR_WIDTH(9), .READ_LATENCY(1),
    .COLLISION_MODE(0), .CNT_WIDTH(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(a_dout0), .dout0_valid(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dout1_valid(a_v1),
    .oob_err(a_oob), .collision(a_coll), .coll_cnt(a_cnt)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .DEPTH(512), .ADDR_WIDTH(9), .READ_LATENCY(2),
    .COLLISION_MODE(1), .CNT_WIDTH(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_dout0), .dout0_valid(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dout1_valid(b_v1),
    .oob_err(b_oob), .collision(b_coll), .coll_cnt(b_cnt)
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        mon_v[4];
  logic [31:0] mon_d[4];
  logic [1:0]  mon_f[2];

  always @(negedge clk) begin
    mon_v = '{a_v0, a_v1, b_v0, b_v1};
    mon_d = '{a_dout0, a_dout1, b_dout0, b_dout1};
    mon_f = '{{a_oob, a_coll}, {b_oob, b_coll}};
    for (int p = 0; p < 4; p++) begin
      if (mon_v[p] === 1'b1) begin
        if (exp_q[p].size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL %s_unexpected_valid: got valid with data %h expected no valid", pname[p], mon_d[p]);
        end else begin
          check(pname[p], mon_d[p], exp_q[p].pop_front());
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (flag_q[d].size() != 0) begin
        check(d == 0 ? "a_oob_coll" : "b_oob_coll", 32'(mon_f[d]), 32'(flag_q[d].pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Applies inputs for the next edge, then records
  // the strobes expected from that edge for each instance.
  task automatic step(input logic c0, input logic w0, input logic [3:0] m0,
                      input logic [8:0] a0, input logic [31:0] d0,
                      input logic c1, input logic [8:0] a1,
                      input logic [1:0] fa, input logic [1:0] fb);
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0;
    csb1 = c1; addr1 = a1;
    @(posedge clk);
    flag_q[0].push_back(fa);
    flag_q[1].push_back(fb);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b1, 9'h0, 2'b00, 2'b00);
  endtask

  task automatic push_rd(input int port, input logic [31:0] ea, input logic [31:0] eb);
    exp_q[port].push_back(ea);
    exp_q[port + 2].push_back(eb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a_douts", a_dout0 | a_dout1, 32'h0);
    check("reset_b_douts", b_dout0 | b_dout1, 32'h0);
    check("reset_strobes", {28'h0, a_v0 | a_v1 | b_v0 | b_v1, a_oob, a_coll, b_oob | b_coll}, 32'h0);
    check("reset_cnts", {14'h0, a_cnt, b_cnt}, 32'h0);
    rst_n = 1'b1;

    // Full write, then a port 1 read.
    step(1'b0, 1'b0, 4'hF, 9'h010, 32'hDEADBEEF, 1'b1, 9'h0, 2'b00, 2'b00);
    push_rd(1, 32'hDEADBEEF, 32'hDEADBEEF);
    step(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h010, 2'b00, 2'b00);

    // Partial byte write over a preloaded word.
    step(1'b0, 1'b0, 4'hF, 9'h020, 32'h11223344, 1'b1, 9'h0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 4'b0101, 9'h020, 32'hAABBCCDD, 1'b1, 9'h0, 2'b00, 2'b00);
    push_rd(0, 32'h11BB33DD, 32'h11BB33DD);
    step(1'b0, 1'b1, 4'h0, 9'h020, 32'h0, 1'b1, 9'h0, 2'b00, 2'b00);

    // Same-address collision: WRITE_FIRST sees the new word, READ_FIRST sees the old one.
    step(1'b0, 1'b0, 4'hF, 9'h030, 32'h0, 1'b1, 9'h0, 2'b00, 2'b00);
    push_rd(1, 32'hCAFEF00D, 32'h0);
    step(1'b0, 1'b0, 4'hF, 9'h030, 32'hCAFEF00D, 1'b0, 9'h030, 2'b01, 2'b01);

    // Two reads of the same address are not a collision.
    push_rd(0, 32'hCAFEF00D, 32'hCAFEF00D);
    push_rd(1, 32'hCAFEF00D, 32'hCAFEF00D);
    step(1'b0, 1'b1, 4'h0, 9'h030, 32'h0, 1'b0, 9'h030, 2'b00, 2'b00);

    // A write with mask 0 leaves the word unchanged.
    step(1'b0, 1'b0, 4'h0, 9'h010, 32'h0, 1'b1, 9'h0, 2'b00, 2'b00);
    push_rd(1, 32'hDEADBEEF, 32'hDEADBEEF);
    step(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h010, 2'b00, 2'b00);
    idle(2);
    check("cnt_a_after_one", 32'(a_cnt), 32'd1);
    check("cnt_b_after_one", 32'(b_cnt), 32'd1);

    // 0x1F8 = 504 is out of range for u_a (DEPTH 500) but in range for u_b.
    step(1'b0, 1'b0, 4'hF, 9'h1F8, 32'h12345678, 1'b1, 9'h0, 2'b10, 2'b00);
    push_rd(1, 32'h0, 32'h12345678);
    step(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h1F8, 2'b10, 2'b00);
    push_rd(0, 32'h0, 32'h12345678);
    step(1'b0, 1'b1, 4'h0, 9'h1F8, 32'h0, 1'b1, 9'h0, 2'b10, 2'b00);
    push_rd(1, 32'h0, 32'h12345678);
    step(1'b0, 1'b0, 4'hF, 9'h1F8, 32'h87654321, 1'b0, 9'h1F8, 2'b10, 2'b01);
    idle(3);
    check("cnt_a_oob_no_count", 32'(a_cnt), 32'd1);
    check("cnt_b_after_two", 32'(b_cnt), 32'd2);

    // Reset lands while a latency-2 read is in flight. u_a has already returned its word.
    exp_q[1].push_back(32'hDEADBEEF);
    step(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h010, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_b_dout1", b_dout1, 32'h0);
    check("midrst_a_dout1", a_dout1, 32'h0);
    idle(2);
    check("midrst_b_no_valid", {31'h0, b_v1}, 32'h0);
    rst_n = 1'b1;
    push_rd(0, 32'h11BB33DD, 32'h11BB33DD);
    push_rd(1, 32'h0, 32'h87654321);
    step(1'b0, 1'b1, 4'h0, 9'h020, 32'h0, 1'b0, 9'h1F8, 2'b10, 2'b00);
    idle(3);
    check("cnt_a_after_reset", 32'(a_cnt), 32'd0);
    check("cnt_b_after_reset", 32'(b_cnt), 32'd0);

    // Five back-to-back collisions. The 2-bit counter saturates at 3.
    step(1'b0, 1'b0, 4'hF, 9'h040, 32'h0, 1'b1, 9'h0, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      push_rd(1, 32'(k), 32'(k - 1));
      step(1'b0, 1'b0, 4'hF, 9'h040, 32'(k), 1'b0, 9'h040, 2'b01, 2'b01);
    end
    idle(3);
    check("cnt_a_saturated", 32'(a_cnt), 32'd3);
    check("cnt_b_five", 32'(b_cnt), 32'd5);

    @(negedge clk);
    #1;
    for (int p = 0; p < 4; p++) check({pname[p], "_pending"}, 32'(exp_q[p].size()), 32'd0);
    check("flags_pending", 32'(flag_q[0].size() + flag_q[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
